// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file with optional write-to-read bypass
//
// Purpose:
//   General-purpose register file for the single-cycle CPU datapath. Two
//   combinational read ports feed the ALU operands. One synchronous write
//   port takes the writeback value. Entry 0 is hardwired to zero. A debug
//   read port is provided for the bench and display logic.
//
// Ports:
//   clk     in   1       clock; writes take effect on the rising edge
//   rst     in   1       asynchronous reset, active-high
//   rna     in   ADDR_W  read index, port A
//   rnb     in   ADDR_W  read index, port B
//   qa      out  DATA_W  read data A (ALU operand a)
//   qb      out  DATA_W  read data B (ALU operand b / store data)
//   we      in   1       write enable
//   wn      in   ADDR_W  write index
//   d       in   DATA_W  write data
//   dbg_rn  in   ADDR_W  debug read index
//   dbg_q   out  DATA_W  debug read data, never bypassed

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  input  logic              we,
  input  logic [ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0] d,
  input  logic [ADDR_W-1:0] dbg_rn,
  output logic [DATA_W-1:0] dbg_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];

  // A write to index 0 is dropped here, so entry 0 stays at its reset value.
  logic wr_en_d;
  assign wr_en_d = we && (wn != '0);

  // The reset branch has priority, so a write pending on the edge where rst
  // is high (including the cycle it asserts) is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wn] <= d;
    end
  end

  // Bypass qualifies on !rst so that the reads return 0 for as long as
  // reset is held, even when we is still high.
  logic bypass_a;
  logic bypass_b;
  assign bypass_a = (BYPASS != 0) && !rst && wr_en_d && (wn == rna);
  assign bypass_b = (BYPASS != 0) && !rst && wr_en_d && (wn == rnb);

  always_comb begin
    qa    = '0;
    qb    = '0;
    dbg_q = '0;
    if (!rst) begin
      if (rna != '0) begin
        qa = regs_q[rna];
      end
      if (rnb != '0) begin
        qb = regs_q[rnb];
      end
      if (dbg_rn != '0) begin
        dbg_q = regs_q[dbg_rn];
      end
      if (bypass_a) begin
        qa = d;
      end
      if (bypass_b) begin
        qb = d;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file, bypass and non-bypass builds
`timescale 1ns/100ps

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rna = '0;
  logic [4:0]  rnb = '0;
  logic        we  = 1'b0;
  logic [4:0]  wn  = '0;
  logic [31:0] d   = '0;
  logic [4:0]  dbg_rn = '0;
  logic [31:0] qa1, qb1, dbg1;
  logic [31:0] qa0, qb0, dbg0;

  int checks = 0;
  int errors = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
    .we(we), .wn(wn), .d(d), .dbg_rn(dbg_rn), .dbg_q(dbg1)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
    .we(we), .wn(wn), .d(d), .dbg_rn(dbg_rn), .dbg_q(dbg0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [4:0]  dbg_rn;
    logic [31:0] qa1;
    logic [31:0] qb1;
    logic [31:0] qa0;
    logic [31:0] qb0;
    logic [31:0] dbg;
  } vec_t;

  typedef struct {
    logic [31:0] qa1;
    logic [31:0] qb1;
    logic [31:0] qa0;
    logic [31:0] qb0;
    logic [31:0] dbg;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  logic [31:0] mdl[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the pre-edge outputs of both builds against the oldest expectation.
  task automatic pop_and_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " qa byp"}, qa1, e.qa1);
      check({tag, " qb byp"}, qb1, e.qb1);
      check({tag, " qa nob"}, qa0, e.qa0);
      check({tag, " qb nob"}, qb0, e.qb0);
      check({tag, " dbg byp"}, dbg1, e.dbg);
      check({tag, " dbg nob"}, dbg0, e.dbg);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 1; i < 32; i++) begin
      dbg_rn = 5'(i);
      rna    = 5'(i);
      rnb    = 5'(31 - i + 1);
      #0.1;
      check({tag, " dbg byp"}, dbg1, 32'h0);
      check({tag, " dbg nob"}, dbg0, 32'h0);
      check({tag, " qa byp"}, qa1, 32'h0);
      check({tag, " qb nob"}, qb0, 32'h0);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] pat;

    //             we  wn  d             rna rnb dbg  qa1           qb1           qa0           qb0           dbg
    vecs[0]  = '{1'b1, 7,  32'h12345678, 7,  7,  7,   32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 0,  32'h0,        7,  7,  7,   32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[2]  = '{1'b1, 0,  32'hFFFFFFFF, 0,  0,  0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 0,  32'h0,        0,  7,  0,   32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h0};
    vecs[4]  = '{1'b1, 3,  32'h00000001, 3,  2,  3,   32'h00000001, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b1, 3,  32'hA5A5A5A5, 3,  3,  3,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001, 32'h00000001, 32'h00000001};
    vecs[6]  = '{1'b0, 0,  32'h0,        3,  7,  3,   32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 3,  32'h0000BEEF, 3,  7,  3,   32'h0000BEEF, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 3,  32'hCAFE0000, 3,  7,  3,   32'hCAFE0000, 32'h12345678, 32'h0000BEEF, 32'h12345678, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 0,  32'h0,        3,  3,  3,   32'hCAFE0000, 32'hCAFE0000, 32'hCAFE0000, 32'hCAFE0000, 32'hCAFE0000};
    vecs[10] = '{1'b1, 31, 32'h80000001, 31, 30, 31,  32'h80000001, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b0, 0,  32'h0,        31, 31, 31,  32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001};

    // Reset: assert rst, then pulse clk with a write pending.
    #2 rst = 1'b1;
    we = 1'b1; wn = 5'd5; d = 32'hDEADBEEF; rna = 5'd5; rnb = 5'd5; dbg_rn = 5'd5;
    #1;
    check("rst qa byp", qa1, 32'h0);
    check("rst qb byp", qb1, 32'h0);
    check("rst dbg byp", dbg1, 32'h0);
    @(posedge clk); #1;
    check("rst write dbg byp", dbg1, 32'h0);
    check("rst write dbg nob", dbg0, 32'h0);
    check("rst write qa byp", qa1, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("post-reset");

    // Table-driven vectors, one per cycle; expectations queued at drive time.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = vecs[i].we; wn = vecs[i].wn; d = vecs[i].d;
      rna = vecs[i].rna; rnb = vecs[i].rnb; dbg_rn = vecs[i].dbg_rn;
      sb.push_back('{vecs[i].qa1, vecs[i].qb1, vecs[i].qa0, vecs[i].qb0, vecs[i].dbg});
      #2;
      pop_and_compare($sformatf("vec%0d", i));
    end

    // Fill r1..r31, then assert reset between edges.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wn = 5'(i); d = i * 32'h01010101;
    end
    @(negedge clk);
    we = 1'b0;
    dbg_rn = 5'd31; #0.5;
    check("fill r31", dbg0, 32'h1F1F1F1F);
    dbg_rn = 5'd9; rna = 5'd9; rnb = 5'd1; #0.5;
    check("fill r9", dbg1, 32'h09090909);
    check("fill qa r9 nob", qa0, 32'h09090909);
    check("fill qb r1 byp", qb1, 32'h01010101);

    @(negedge clk);
    we = 1'b1; wn = 5'd9; d = 32'h0000FFFF;
    #1 rst = 1'b1;
    #0.4;
    check_all_zero("mid-rst");
    repeat (2) @(posedge clk);
    // Release between edges with a write waiting; the next edge must take it.
    @(negedge clk);
    d = 32'h00000077;
    #1 rst = 1'b0;
    dbg_rn = 5'd9; rna = 5'd9; #0.5;
    check("release pre-edge dbg", dbg1, 32'h0);
    check("release pre-edge qa byp", qa1, 32'h00000077);
    check("release pre-edge qa nob", qa0, 32'h0);
    @(posedge clk); #1;
    check("release write dbg byp", dbg1, 32'h00000077);
    check("release write dbg nob", dbg0, 32'h00000077);
    @(negedge clk);
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (i != 9) begin
        dbg_rn = 5'(i); #0.1;
        check("rst cleared", dbg0, 32'h0);
      end
    end

    // Random traffic against a reference array model.
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[9] = 32'h00000077;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      wn = 5'($urandom_range(0, 31));
      d  = $urandom;
      rna = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      rnb = 5'($urandom_range(0, 31));
      dbg_rn = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      e.qa0 = (rna == 0) ? 32'h0 : mdl[rna];
      e.qb0 = (rnb == 0) ? 32'h0 : mdl[rnb];
      e.qa1 = (we && wn != 0 && wn == rna) ? d : e.qa0;
      e.qb1 = (we && wn != 0 && wn == rnb) ? d : e.qb0;
      e.dbg = (dbg_rn == 0) ? 32'h0 : mdl[dbg_rn];
      sb.push_back(e);
      #2;
      pop_and_compare("rand");
      if (we && wn != 0) mdl[wn] = d;
    end

    @(negedge clk);
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      dbg_rn = 5'(i); #0.1;
      pat = mdl[i];
      check("rand final", dbg1, pat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
